// File: rtl/cam_pixel_capture.sv
// Camera RGB444 byte stream -> decimated 320x240 draw points with frame/line error tracking.
// Optional build macro CAM_CAPTURE_TEST_PATTERN_EN adds piul1TestPattern to replace camera colour with a position pattern.
module cam_pixel_capture #(
  parameter int P_IN_HRES = 640,
  parameter int P_IN_VRES = 480
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1VSync,
  input  logic        piul1HRef,
  input  logic [7:0]  piul8Data,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  input  logic        piul1TestPattern,
`endif
  output logic [8:0]  poul9PosX,
  output logic [8:0]  poul9PosY,
  output logic [11:0] poul12Rgb12Data,
  output logic        poul1Update,
  output logic        poul1FrameDone,
  output logic        poul1LineErr,
  output logic [15:0] poul16FrameCount
);

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_FRAME,
    WAIT_LINE,
    BYTE_HI,
    BYTE_LO
  } state_t;

  localparam logic [10:0] HRES_W = 11'(P_IN_HRES);
  localparam logic [10:0] VRES_W = 11'(P_IN_VRES);

  state_t      state_q, state_d;
  // One bit wider than the 10-bit range and saturating, so overlong lines never alias back into range.
  logic [10:0] pix_q, pix_d;
  logic [10:0] line_q, line_d;
  logic [3:0]  red_q, red_d;
  logic [8:0]  posx_q, posx_d;
  logic [8:0]  posy_q, posy_d;
  logic [11:0] rgb_q, rgb_d;
  logic        upd_q, upd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        keep;
  logic [8:0]  posx_n;
  logic [8:0]  posy_n;
  logic [11:0] rgb_n;
  logic [10:0] pix_inc;
  logic [10:0] line_inc;

  always_comb begin
    posx_n   = pix_q[9:1];
    posy_n   = line_q[9:1];
    pix_inc  = (pix_q == 11'h7ff) ? pix_q : pix_q + 11'd1;
    line_inc = (line_q == 11'h7ff) ? line_q : line_q + 11'd1;
    keep     = !pix_q[0] && !line_q[0] && (pix_q < HRES_W) && (line_q < VRES_W);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    rgb_n    = piul1TestPattern ? {posx_n[8:5], posy_n[7:4], ~posx_n[8:5]}
                                : {red_q, piul8Data};
`else
    rgb_n    = {red_q, piul8Data};
`endif
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    red_d   = red_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    rgb_d   = rgb_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      WAIT_VS: begin
        if (piul1VSync) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!piul1VSync) begin
          state_d = WAIT_LINE;
          pix_d   = '0;
          line_d  = '0;
          err_d   = 1'b0;
        end
      end
      WAIT_LINE, BYTE_HI, BYTE_LO: begin
        if (piul1VSync) begin
          // A frame only counts if every expected line arrived cleanly.
          state_d = WAIT_FRAME;
          pix_d   = '0;
          if ((line_q == VRES_W) && !err_q) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
          end
        end else if (piul1HRef) begin
          if (state_q == BYTE_LO) begin
            state_d = BYTE_HI;
            pix_d   = pix_inc;
            if (keep) begin
              upd_d  = 1'b1;
              posx_d = posx_n;
              posy_d = posy_n;
              rgb_d  = rgb_n;
            end
          end else begin
            state_d = BYTE_LO;
            red_d   = piul8Data[3:0];
          end
        end else if (state_q != WAIT_LINE) begin
          state_d = WAIT_LINE;
          pix_d   = '0;
          line_d  = line_inc;
          if ((state_q == BYTE_LO) || (pix_q != HRES_W) || (line_q >= VRES_W)) err_d = 1'b1;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q <= WAIT_VS;
      pix_q   <= '0;
      line_q  <= '0;
      red_q   <= '0;
      posx_q  <= '0;
      posy_q  <= '0;
      rgb_q   <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      red_q   <= red_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      rgb_q   <= rgb_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign poul9PosX        = posx_q;
  assign poul9PosY        = posy_q;
  assign poul12Rgb12Data  = rgb_q;
  assign poul1Update      = upd_q;
  assign poul1FrameDone   = done_q;
  assign poul1LineErr     = err_q;
  assign poul16FrameCount = fcnt_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture on a reduced 8x6-pixel input frame (16 bytes per line).
module tb_cam_pixel_capture;

  localparam int HRES = 8;
  localparam int VRES = 6;

  logic        clk;
  logic        rst;
  logic        vs;
  logic        href;
  logic [7:0]  data;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  logic        tp;
`endif
  logic [8:0]  posx;
  logic [8:0]  posy;
  logic [11:0] rgb;
  logic        upd;
  logic        fdone;
  logic        lerr;
  logic [15:0] fcnt;

  int n_checks = 0;
  int n_pass   = 0;
  int upd_total = 0;
  int fd_total  = 0;
  int base;
  int fd_base;
  logic [8:0]  last_x;
  logic [8:0]  last_y;
  logic [11:0] last_rgb;
  logic [11:0] rgb_at [0:7][0:7];

  cam_pixel_capture #(.P_IN_HRES(HRES), .P_IN_VRES(VRES)) dut (
    .piul1Clock       (clk),
    .piul1Reset       (rst),
    .piul1VSync       (vs),
    .piul1HRef        (href),
    .piul8Data        (data),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    .piul1TestPattern (tp),
`endif
    .poul9PosX        (posx),
    .poul9PosY        (posy),
    .poul12Rgb12Data  (rgb),
    .poul1Update      (upd),
    .poul1FrameDone   (fdone),
    .poul1LineErr     (lerr),
    .poul16FrameCount (fcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd) begin
      upd_total = upd_total + 1;
      last_x    = posx;
      last_y    = posy;
      last_rgb  = rgb;
      if (posx < 8 && posy < 8) rgb_at[posy[2:0]][posx[2:0]] = rgb;
    end
    if (fdone) fd_total = fd_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Called at a negedge; byte b of line l carries l*16+b.
  task automatic send_line(input int l, input int nb, input int first);
    for (int b = first; b < nb; b++) begin
      href = 1'b1;
      data = 8'(l * 16 + b);
      @(negedge clk);
    end
    href = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_vsync(input logic exp_done, input logic exp_err);
    vs = 1'b1;
    @(negedge clk);
    check("vs_frame_done", fdone, exp_done);
    check("vs_line_err", lerr, exp_err);
    repeat (2) @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; vs = 1'b0; href = 1'b0; data = 8'h00;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    tp = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_update", upd, 0);
    check("rst_done", fdone, 0);
    check("rst_err", lerr, 0);
    check("rst_fcnt", fcnt, 0);
    check("rst_posx", posx, 0);
    check("rst_posy", posy, 0);
    check("rst_rgb", rgb, 0);
    rst = 1'b0;
    @(negedge clk);

    // No capture before a VSync high->low sequence
    base = upd_total;
    send_line(0, 16, 0);
    check("pre_vs_upd", upd_total - base, 0);
    do_vsync(1'b0, 1'b0);

    // Frame A: full incrementing frame
    base = upd_total;
    fd_base = fd_total;
    for (int l = 0; l < VRES; l++) send_line(l, 16, 0);
    check("a_upd_count", upd_total - base, 12);
    check("a_last_x", last_x, 3);
    check("a_last_y", last_y, 2);
    check("a_last_rgb", last_rgb, 12'hC4D);
    check("a_rgb_0_0", rgb_at[0][0], 12'h001);
    check("a_rgb_1_1", rgb_at[1][1], 12'h425);
    check("a_err", lerr, 0);
    do_vsync(1'b1, 1'b0);
    check("a_fd_once", fd_total - fd_base, 1);
    check("a_fcnt", fcnt, 1);

    // Frame B: first pixel 0x0A,0x5C; strobe one cycle after the low byte
    href = 1'b1; data = 8'h0A;
    @(negedge clk);
    check("b_upd_after_hi", upd, 0);
    data = 8'h5C;
    @(negedge clk);
    check("b_upd", upd, 1);
    check("b_x", posx, 0);
    check("b_y", posy, 0);
    check("b_rgb", rgb, 12'hA5C);
    send_line(0, 16, 2);
    base = upd_total;
    send_line(1, 16, 0);
    check("b_odd_line_upd", upd_total - base, 0);
    for (int l = 2; l < VRES; l++) send_line(l, 16, 0);
    do_vsync(1'b1, 1'b0);
    check("b_fcnt", fcnt, 2);

    // Frame C: odd byte count on line 0
    send_line(0, 15, 0);
    check("c_err_set", lerr, 1);
    for (int l = 1; l < VRES; l++) send_line(l, 16, 0);
    do_vsync(1'b0, 1'b1);
    check("c_fcnt", fcnt, 2);
    check("c_err_cleared", lerr, 0);

    // Frame D: aborted after 3 lines
    for (int l = 0; l < 3; l++) send_line(l, 16, 0);
    do_vsync(1'b0, 1'b0);
    check("d_fcnt", fcnt, 2);

    // Frame E: normal frame after abort
    base = upd_total;
    for (int l = 0; l < VRES; l++) send_line(l, 16, 0);
    check("e_upd_count", upd_total - base, 12);
    do_vsync(1'b1, 1'b0);
    check("e_fcnt", fcnt, 3);

    // Frame F: one line too many
    base = upd_total;
    for (int l = 0; l < VRES + 1; l++) send_line(l, 16, 0);
    check("f_upd_count", upd_total - base, 12);
    check("f_err", lerr, 1);
    do_vsync(1'b0, 1'b1);
    check("f_fcnt", fcnt, 3);

    // Frame G: reset in the middle of a line
    send_line(0, 16, 0);
    check("g_posx_before", posx, 3);
    for (int b = 0; b < 4; b++) begin
      href = 1'b1; data = 8'(16 + b);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("g_rst_update", upd, 0);
    check("g_rst_posx", posx, 0);
    check("g_rst_rgb", rgb, 0);
    check("g_rst_fcnt", fcnt, 0);
    check("g_rst_err", lerr, 0);
    rst = 1'b0; href = 1'b0; data = 8'h00;
    @(negedge clk);
    base = upd_total;
    send_line(2, 16, 0);
    send_line(3, 16, 0);
    check("g_no_upd_after_rst", upd_total - base, 0);
    do_vsync(1'b0, 1'b0);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    tp = 1'b1;
`endif
    base = upd_total;
    for (int l = 0; l < VRES; l++) send_line(l, 16, 0);
    check("g_upd_count", upd_total - base, 12);
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    check("g_tp_rgb", last_rgb, 12'h00F);
`endif
    do_vsync(1'b1, 1'b0);
    check("g_fcnt", fcnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
